// File: rtl/mph_pkg.sv
// Shared definitions for the multi-project pad harness: register map, window
// geometry, switch FSM states and STATUS layout.
package mph_pkg;

    localparam logic [7:0] OFF_ACTIVE = 8'h00;
    localparam logic [7:0] OFF_OEB_LO = 8'h04;
    localparam logic [7:0] OFF_OEB_HI = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    // 0x100 window stride: page 0 is the harness, page k+1 is project k
    localparam int WIN_SHIFT = 8;

    localparam int ST_SWITCHING = 0;
    localparam int ST_TARGET_LSB = 8;
    localparam int ST_NPROJ_LSB = 16;

    typedef enum logic {
        IDLE,
        GUARD
    } sw_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    function automatic logic [31:0] status_word(input logic sw, input logic [7:0] tgt,
                                                input logic [7:0] np);
        logic [31:0] w;
        w = '0;
        w[ST_SWITCHING] = sw;
        w[ST_TARGET_LSB +: 8] = tgt;
        w[ST_NPROJ_LSB +: 8] = np;
        return w;
    endfunction

endpackage

// File: rtl/harness_switch_fsm.sv
// Project switch controller: latches the requested target and holds the guard
// window for GUARD_CYCLES+1 clocks before committing it as the active project.
module harness_switch_fsm
    import mph_pkg::*;
#(
    parameter int GUARD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] req_id,
    output logic       switching,
    output logic [7:0] active_id,
    output logic [7:0] target_id
);

    localparam int CW = $clog2(GUARD_CYCLES + 1);

    sw_state_t     state;
    logic [CW-1:0] cnt;

    // A request always wins, so a write mid-guard restarts the full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= GUARD;
            cnt       <= CW'(GUARD_CYCLES);
            target_id <= '0;
            active_id <= '0;
        end else if (req) begin
            state     <= GUARD;
            cnt       <= CW'(GUARD_CYCLES);
            target_id <= req_id;
        end else if (state == GUARD) begin
            if (cnt == '0) begin
                active_id <= target_id;
                state     <= IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign switching = (state == GUARD);

endmodule

// File: rtl/multi_project_harness_gen2.sv
// Wishbone-controlled pad mux selecting one of NUM_PROJ user projects, with a
// guarded switch-over, OEB registers, status read-back and per-project windows.
module multi_project_harness_gen2
    import mph_pkg::*;
#(
    parameter int          NUM_PROJ     = 8,
    parameter int          IO_PADS      = 38,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          GUARD_CYCLES = 16
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [31:0]                  wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    input  logic [IO_PADS-1:0]           io_in,
    output logic [IO_PADS-1:0]           io_out,
    output logic [IO_PADS-1:0]           io_oeb,
    output logic [NUM_PROJ*IO_PADS-1:0]  proj_io_in,
    input  logic [NUM_PROJ*IO_PADS-1:0]  proj_io_out,
    output logic [NUM_PROJ-1:0]          proj_reset,
    output logic [NUM_PROJ-1:0]          proj_wb_update
);

    localparam int HI_W = IO_PADS - 32;
    localparam int PW   = 32 - WIN_SHIFT;

    wb_req_t       req_in;
    logic          valid, hit, wr, is_reg;
    logic [31:0]   rel;
    logic [PW-1:0] page;
    logic [7:0]    off;

    assign req_in = '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};
    assign valid  = wbs_cyc_i & wbs_stb_i;
    assign rel    = req_in.adr - BASE_ADDR;
    assign page   = rel[31:WIN_SHIFT];
    assign off    = rel[WIN_SHIFT-1:0];
    assign is_reg = (page == '0);
    // Masking with the current ack keeps acks from landing on back-to-back cycles.
    assign hit    = valid & ~wbs_ack_o & (page <= PW'(NUM_PROJ));
    assign wr     = hit & req_in.we;

    logic       sw_req, switching;
    logic [7:0] active_id, target_id;

    assign sw_req = wr & is_reg & (off == OFF_ACTIVE) & req_in.sel[0];

    harness_switch_fsm #(
        .GUARD_CYCLES(GUARD_CYCLES)
    ) u_fsm (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .req       (sw_req),
        .req_id    (req_in.dat[7:0]),
        .switching (switching),
        .active_id (active_id),
        .target_id (target_id)
    );

    logic [31:0]     oeb_lo;
    logic [HI_W-1:0] oeb_hi;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            oeb_lo <= '1;
            oeb_hi <= '1;
        end else if (wr && is_reg && req_in.sel == 4'hF) begin
            if (off == OFF_OEB_LO) oeb_lo <= req_in.dat;
            if (off == OFF_OEB_HI) oeb_hi <= req_in.dat[HI_W-1:0];
        end
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (is_reg) begin
            case (off)
                OFF_ACTIVE: rdata = {24'h0, active_id};
                OFF_OEB_LO: rdata = oeb_lo;
                OFF_OEB_HI: rdata = 32'(oeb_hi);
                OFF_STATUS: rdata = status_word(switching, target_id, 8'(NUM_PROJ));
                default:    rdata = '0;
            endcase
        end
    end

    logic [NUM_PROJ-1:0] upd_next;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            proj_wb_update <= '0;
        end else begin
            wbs_ack_o      <= hit;
            wbs_dat_o      <= (hit && !req_in.we) ? rdata : '0;
            proj_wb_update <= upd_next;
        end
    end

    // Pad routing: only the committed project, and only outside the guard.
    logic route_ok;
    logic [NUM_PROJ-1:0]              lane_sel;
    logic [NUM_PROJ-1:0][IO_PADS-1:0] lane_in, lane_out, lane_drv;

    assign route_ok = ~switching && (active_id < 8'(NUM_PROJ));
    assign lane_out = proj_io_out;

    genvar k;
    generate
        for (k = 0; k < NUM_PROJ; k++) begin : g_lane
            assign upd_next[k] = wr && (page == PW'(k + 1));
            assign lane_sel[k] = route_ok && (active_id == 8'(k));
            assign lane_in[k]  = lane_sel[k] ? io_in : '0;
            assign lane_drv[k] = lane_sel[k] ? lane_out[k] : '0;
        end
    endgenerate

    assign proj_io_in = lane_in;
    assign proj_reset = ~lane_sel;
    assign io_oeb     = route_ok ? {oeb_hi, oeb_lo} : '1;

    always_comb begin
        io_out = '0;
        for (int i = 0; i < NUM_PROJ; i++) io_out |= lane_drv[i];
    end

endmodule
